// File: rtl/lsu_port_pkg.sv
// Shared types for the load/store port: access-mode enum, default memory depth
// and the alignment rule used when a request is accepted.
package lsu_port_pkg;

   localparam int unsigned RAM_SIZE_LOG = 8;

   typedef enum logic [2:0] {
      BYTE   = 3'd0,
      HALF   = 3'd1,
      WORD   = 3'd2,
      BYTE_U = 3'd3,
      HALF_U = 3'd4
   } ldst_mode;

   function automatic logic misaligned(input ldst_mode mode, input logic [1:0] off);
      case (mode)
         HALF, HALF_U: misaligned = off[0];
         WORD:         misaligned = (off != 2'b00);
         default:      misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_port_lane_merge.sv
// Combinational byte/half lane handling: inserts store data into a word and
// extracts the addressed lane of a word with sign or zero extension.
module lane_merge
   import lsu_port_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  ldst_mode    i_mode,
   input  logic [1:0]  i_off,
   output logic [31:0] o_merged,
   output logic [31:0] o_extract
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[{i_off, 3'b000} +: 8];
      w_half = i_word[{i_off[1], 4'b0000} +: 16];
   end

   always_comb begin
      o_merged  = i_word;
      o_extract = i_word;
      case (i_mode)
         BYTE, BYTE_U: begin
            o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            o_extract = (i_mode == BYTE) ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
         end
         HALF, HALF_U: begin
            o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            o_extract = (i_mode == HALF) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
         end
         default: begin
            o_merged  = i_wdata;
            o_extract = i_word;
         end
      endcase
   end

endmodule

// File: rtl/lsu_port.sv
// Single-outstanding load/store port in front of a word-wide data memory;
// sub-word stores are done as read-modify-write of the containing word.
module lsu_port
   import lsu_port_pkg::*;
#(
   parameter int unsigned RAM_SIZE_LOG = lsu_port_pkg::RAM_SIZE_LOG
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  ldst_mode                req_mode,
   input  logic [31:0]             req_addr,
   input  logic [31:0]             req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [31:0]             resp_rdata,
   output logic                    resp_err,
   output logic [RAM_SIZE_LOG-1:0] mem_addr,
   input  logic [31:0]             mem_rdata,
   output logic                    mem_we,
   output logic [31:0]             mem_wdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]              r_state;
   logic                    r_we;
   ldst_mode                r_mode;
   logic [RAM_SIZE_LOG+1:0] r_addr;
   logic [31:0]             r_wdata;
   logic [31:0]             r_rdata;
   logic [31:0]             r_mwdata;
   logic                    r_err;

   logic                    w_accept;
   logic                    w_range_err;
   logic                    w_err;
   logic [31:0]             w_merged;
   logic [31:0]             w_extract;

   assign req_ready   = (r_state == ST_IDLE);
   assign w_accept    = req_valid && req_ready;
   assign w_range_err = ((req_addr >> (RAM_SIZE_LOG + 2)) != 32'd0);
   assign w_err       = misaligned(req_mode, req_addr[1:0]) || w_range_err;

   assign resp_valid = (r_state == ST_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   assign mem_addr   = r_addr[RAM_SIZE_LOG+1:2];
   assign mem_we     = (r_state == ST_WRITE);
   assign mem_wdata  = r_mwdata;

   lane_merge u_lane_merge (
      .i_word    (mem_rdata),
      .i_wdata   (r_wdata),
      .i_mode    (r_mode),
      .i_off     (r_addr[1:0]),
      .o_merged  (w_merged),
      .o_extract (w_extract)
   );

   // The memory word is consumed in READ already processed: lane-extracted for
   // loads, lane-merged for stores, so WRITE only has to pulse the enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_we     <= 1'b0;
         r_mode   <= BYTE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_mwdata <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_we    <= req_we;
                  r_mode  <= req_mode;
                  r_addr  <= req_addr[RAM_SIZE_LOG+1:0];
                  r_wdata <= req_wdata;
                  r_rdata <= '0;
                  r_err   <= w_err;
                  r_state <= w_err ? ST_RESP : ST_READ;
               end
            end
            ST_READ: begin
               if (r_we) begin
                  r_mwdata <= w_merged;
                  r_state  <= ST_WRITE;
               end else begin
                  r_rdata <= w_extract;
                  r_state <= ST_RESP;
               end
            end
            ST_WRITE: r_state <= ST_RESP;
            ST_RESP: begin
               if (resp_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_port.sv
// Scoreboard bench for lsu_port: a word-array reference model predicts load
// data, error flags, latency and memory writes; monitors compare the DUT.
module tb_lsu_port;
   import lsu_port_pkg::*;

   localparam int unsigned RSL   = 8;
   localparam int unsigned DEPTH = 1 << RSL;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_we = 1'b0;
   ldst_mode       req_mode = BYTE;
   logic [31:0]    req_addr = '0;
   logic [31:0]    req_wdata = '0;
   logic           resp_valid;
   logic           resp_ready;
   logic [31:0]    resp_rdata;
   logic           resp_err;
   logic [RSL-1:0] mem_addr;
   logic [31:0]    mem_rdata;
   logic           mem_we;
   logic [31:0]    mem_wdata;

   always #5 clk = ~clk;

   lsu_port #(.RAM_SIZE_LOG(RSL)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_mode   (req_mode),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata)
   );

   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic err; logic [31:0] rdata; int cyc; } resp_t;
   typedef struct { logic [RSL-1:0] idx; logic [31:0] data; } wr_t;
   resp_t rq[$];
   wr_t   wq[$];

   int n_chk = 0;
   int n_pass = 0;
   int n_stores = 0;
   int wr_pulses = 0;
   int hold_req = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: plain shift/mask arithmetic over a word array.
   function automatic logic model_err(input ldst_mode m, input logic [31:0] a);
      logic bad;
      bad = (a >= DEPTH * 4);
      if ((m == HALF || m == HALF_U) && (a % 2 != 0)) bad = 1'b1;
      if (m == WORD && (a % 4 != 0)) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input ldst_mode m, input int unsigned off);
      logic [31:0] v;
      v = w >> (off * 8);
      case (m)
         BYTE:   begin v = v & 32'hFF;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
         HALF:   begin v = v & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF_0000; end
         BYTE_U: v = v & 32'hFF;
         HALF_U: v = v & 32'hFFFF;
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] w, input ldst_mode m,
                                               input int unsigned off, input logic [31:0] wd);
      logic [31:0] mask;
      case (m)
         BYTE, BYTE_U: mask = 32'hFF;
         HALF, HALF_U: mask = 32'hFFFF;
         default:      mask = 32'hFFFF_FFFF;
      endcase
      return (w & ~(mask << (off * 8))) | ((wd & mask) << (off * 8));
   endfunction

   task automatic set_word(input int unsigned i, input logic [31:0] v);
      mem[i]     = v;
      ref_mem[i] = v;
   endtask

   // Called at a falling edge; acceptance happens at the next rising edge.
   task automatic issue(input logic we, input ldst_mode m, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_lit, input logic [31:0] lit,
                        input int hold);
      int          waited;
      int unsigned idx;
      int unsigned off;
      resp_t       e;
      logic [31:0] nv;
      waited = 0;
      while (!req_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
         return;
      end
      idx   = (a >> 2) % DEPTH;
      off   = a % 4;
      e.err = model_err(m, a);
      e.rdata = 32'd0;
      if (e.err) e.cyc = cyc + 1;
      else if (we) e.cyc = cyc + 3;
      else e.cyc = cyc + 2;
      if (!e.err && !we) e.rdata = use_lit ? lit : model_load(ref_mem[idx], m, off);
      if (!e.err && we) begin
         nv = use_lit ? lit : model_store(ref_mem[idx], m, off, wd);
         ref_mem[idx] = nv;
         wq.push_back('{idx: idx[RSL-1:0], data: nv});
         n_stores++;
      end
      hold_req = hold;
      rq.push_back(e);
      req_valid = 1'b1;
      req_we    = we;
      req_mode  = m;
      req_addr  = a;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   // Response and memory-write monitor; also acts as the response consumer.
   bit          seen = 0;
   int          hold_cnt = 0;
   logic        wr_prev = 1'b0;
   logic [31:0] cap_rdata;
   logic        cap_err;

   initial begin
      resp_t cur;
      wr_t   w;
      resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            seen = 0;
            hold_cnt = 0;
            wr_prev = 1'b0;
            resp_ready = 1'b0;
         end else begin
            if (mem_we) begin
               wr_pulses++;
               check("mem_we_single_cycle", {31'd0, wr_prev}, 32'd0);
               if (wq.size() == 0) check("unexpected_mem_we", 32'd1, 32'd0);
               else begin
                  w = wq.pop_front();
                  check("mem_addr", {24'd0, mem_addr}, {24'd0, w.idx});
                  check("mem_wdata", mem_wdata, w.data);
               end
            end
            wr_prev = mem_we;
            if (resp_valid) begin
               if (!seen) begin
                  if (rq.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
                  else begin
                     cur = rq[0];
                     seen = 1;
                     check("resp_latency_cycle", cyc, cur.cyc);
                     check("resp_err", {31'd0, resp_err}, {31'd0, cur.err});
                     check("resp_rdata", resp_rdata, cur.rdata);
                     cap_rdata = resp_rdata;
                     cap_err   = resp_err;
                     hold_cnt  = hold_req;
                     hold_req  = 0;
                  end
               end else begin
                  check("hold_rdata_stable", resp_rdata, cap_rdata);
                  check("hold_err_stable", {31'd0, resp_err}, {31'd0, cap_err});
                  check("hold_req_ready_low", {31'd0, req_ready}, 32'd0);
               end
               if (hold_cnt > 0) begin
                  resp_ready = 1'b0;
                  hold_cnt--;
               end else begin
                  resp_ready = ($urandom_range(0, 2) != 0);
               end
               if (resp_ready) begin
                  if (seen && rq.size() > 0) rq.delete(0);
                  seen = 0;
               end
            end else begin
               resp_ready = $urandom_range(0, 1);
            end
         end
      end
   end

   initial begin
      int          nbad;
      int          waited;
      bit          found;
      ldst_mode    m;
      logic [31:0] a;
      int unsigned r;

      for (int unsigned i = 0; i < DEPTH; i++) set_word(i, $urandom);

      #12;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      set_word(1, 32'h1122_3344);
      set_word(2, 32'h0000_F080);
      set_word(3, 32'hAABB_CCDD);
      issue(1'b0, BYTE,   32'h7,   32'h0,  1'b1, 32'h0000_0011, 0);
      issue(1'b0, HALF,   32'h8,   32'h0,  1'b1, 32'hFFFF_F080, 0);
      issue(1'b0, HALF_U, 32'h8,   32'h0,  1'b1, 32'h0000_F080, 0);
      issue(1'b1, BYTE,   32'hD,   32'h55, 1'b1, 32'hAABB_55DD, 0);
      issue(1'b0, WORD,   32'h6,   32'h0,  1'b0, 32'h0, 0);
      issue(1'b1, WORD,   32'h400, 32'h12345678, 1'b0, 32'h0, 0);
      issue(1'b0, WORD,   32'hC,   32'h0,  1'b1, 32'hAABB_55DD, 4);
      issue(1'b1, HALF_U, 32'h3FE, 32'h0000_9ABC, 1'b0, 32'h0, 0);
      issue(1'b0, HALF,   32'h3FE, 32'h0,  1'b0, 32'h0, 0);
      issue(1'b0, BYTE_U, 32'h3FF, 32'h0,  1'b0, 32'h0, 0);
      issue(1'b0, BYTE,   32'h8000_0000, 32'h0, 1'b0, 32'h0, 0);
      issue(1'b1, HALF,   32'h21,  32'hFFFF, 1'b0, 32'h0, 0);

      // Reset while a store sits in WRITE: the word must stay untouched.
      waited = 0;
      while (!req_ready && waited < 100) begin @(negedge clk); waited++; end
      set_word(5, 32'hCAFE_F00D);
      req_valid = 1'b1; req_we = 1'b1; req_mode = WORD;
      req_addr = 32'h14; req_wdata = 32'h1234_5678;
      @(negedge clk);
      req_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk); #1;
         if (mem_we) found = 1;
      end
      check("reset_store_reached_write", {31'd0, found}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("reset_drops_mem_we", {31'd0, mem_we}, 32'd0);
      check("reset_req_ready", {31'd0, req_ready}, 32'd1);
      check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("reset_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_store_mem_unchanged", mem[5], 32'hCAFE_F00D);

      for (int n = 0; n < 150; n++) begin
         m = ldst_mode'($urandom_range(0, 4));
         r = $urandom_range(0, 9);
         if (r == 0) a = $urandom | 32'h0000_0400;
         else begin
            a = $urandom_range(0, DEPTH * 4 - 1);
            if (r < 7) begin
               if (m == HALF || m == HALF_U) a = a & ~32'd1;
               if (m == WORD) a = a & ~32'd3;
            end
         end
         issue($urandom_range(0, 1) == 1, m, a, $urandom, 1'b0, 32'h0,
               ($urandom_range(0, 9) == 0) ? 3 : 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      waited = 0;
      while ((rq.size() != 0 || wq.size() != 0 || !req_ready) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check("drain_resp_queue", rq.size(), 32'd0);
      check("drain_write_queue", wq.size(), 32'd0);
      check("mem_we_pulse_count", wr_pulses, n_stores);
      nbad = 0;
      for (int unsigned i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
      check("mem_image_mismatches", nbad, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter RAM_SIZE_LOG, default 8, meaning log2 of the data-memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, meaning a request is offered.
REQ-005 SHALL have port req_ready, output, 1, meaning a request can be accepted.
REQ-006 SHALL have port req_we, input, 1, where 1 means store and 0 means load.
REQ-007 SHALL have port req_mode, input, ldst_mode, the access width and signedness.
REQ-008 SHALL have port req_addr, input, 32, the byte address.
REQ-009 SHALL have port req_wdata, input, 32, the store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, meaning a response is pending.
REQ-011 SHALL have port resp_ready, input, 1, meaning the consumer takes the response.
REQ-012 SHALL have port resp_rdata, output, 32, the load result, already extended.
REQ-013 SHALL have port resp_err, output, 1, flagging a misaligned or out-of-range access.
REQ-014 SHALL have port mem_addr, output, RAM_SIZE_LOG, the word index into the data memory.
REQ-015 SHALL have port mem_rdata, input, 32, the combinational word read at mem_addr.
REQ-016 SHALL have port mem_we, output, 1, the full-word write enable.
REQ-017 SHALL have port mem_wdata, output, 32, the merged word to write.

Function
REQ-018 SHALL implement an FSM with states IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a request when req_valid and req_ready are both 1, latching we, mode, addr and wdata.
REQ-020 SHALL flag an error on any of: HALF/HALF_U with addr[0]=1; WORD with addr[1:0]!=0; addr[31:RAM_SIZE_LOG+2]!=0.
REQ-021 On an error, SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL never assert mem_we.
REQ-022 Otherwise, SHALL go IDLE->READ; in READ, SHALL drive mem_addr=addr[RAM_SIZE_LOG+1:2] and register mem_rdata.
REQ-023 For a load, SHALL go READ->RESP and set resp_rdata to:
- BYTE/HALF: the lane selected by addr[1:0], sign-extended;
- BYTE_U/HALF_U: the same lane, zero-extended;
- WORD: the whole word.
REQ-024 For a store, SHALL go READ->WRITE and merge req_wdata[7:0] or [15:0] into the selected lane of the registered word; WORD SHALL replace the whole word; BYTE_U/HALF_U SHALL store the same as BYTE/HALF.
REQ-025 In WRITE, SHALL assert mem_we=1 for exactly one cycle with mem_addr and mem_wdata held stable; the next state SHALL be RESP, and resp_rdata SHALL be 0 for stores.
REQ-026 In RESP, SHALL hold resp_valid=1 with stable data until resp_ready=1, then go to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-027 Latency from acceptance edge to resp_valid SHALL be: load 2 cycles; store 3 cycles; error 1 cycle.
REQ-028 mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-029 While reset_n=0, SHALL force: state=IDLE; req_ready=1 once released; resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset asserted mid-store SHALL drop mem_we immediately, leave the memory word unwritten if WRITE has not completed, and discard the request.

Structure
REQ-031 SHALL take the ldst_mode enum (BYTE, HALF, WORD, BYTE_U, HALF_U) and RAM_SIZE_LOG from the shared package.
REQ-032 SHALL have one sub-module, lane_merge: a combinational byte/half lane insert and extract with extension.

Verification
REQ-033 mem[1]=0x11223344; load BYTE at 0x7 -> resp_rdata=0x00000011 two cycles after accept.
REQ-034 mem[2]=0x0000F080; load HALF at 0x8 -> 0xFFFFF080; load HALF_U at 0x8 -> 0x0000F080.
REQ-035 mem[3]=0xAABBCCDD; store BYTE 0x55 at 0xD -> one mem_we pulse with mem_wdata=0xAABB55DD, resp after 3 cycles.
REQ-036 Load WORD at 0x6 -> resp_err=1 after 1 cycle, with no mem_we.
REQ-037 Store WORD at 0x400 with RAM_SIZE_LOG=8 -> resp_err=1 and no mem_we.
REQ-038 Hold resp_ready=0 for 4 cycles -> resp_valid and data stay stable and req_ready stays 0; reset_n pulsed during WRITE -> memory unchanged and FSM in IDLE.
